inv_nibble_link_rx: RTL and testbench



---
 rtl/inv_nibble_link_rx_pkg.sv | 19 +
 rtl/inv_link_sync.sv | 32 +++
 rtl/inv_nibble_link_rx.sv | 84 ++++++++
 tb/tb_inv_nibble_link_rx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/inv_nibble_link_rx_pkg.sv
// rtl/inv_nibble_link_rx_pkg.sv - pin map, state encoding and defaults for the inverted nibble link receiver
package inv_nibble_link_rx_pkg;

   localparam int PIN_CLK    = 0;
   localparam int PIN_RST    = 1;
   localparam int PIN_STB    = 2;
   localparam int PIN_DAT_LO = 3;
   localparam int PIN_VIEW   = 7;

   localparam int TIMEOUT_DEFAULT = 255;

   localparam logic STATUS_MARK = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      HALF = 1'b1
   } state_t;

endpackage

// File: rtl/inv_link_sync.sv
// rtl/inv_link_sync.sv - two-flop synchroniser for {dat_n, stb_n} with falling-edge strobe detect
module inv_link_sync #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] raw,
   output logic [W-2:0] nibble,
   output logic         stb_evt
);

   // bit 0 is stb_n, the rest is dat_n; idle-high link, so reset to all ones
   logic [W-1:0] s1;
   logic [W-1:0] s2;
   logic         s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '1;
         s2 <= '1;
         s3 <= 1'b1;
      end else begin
         s1 <= raw;
         s2 <= s1;
         s3 <= s2[0];
      end
   end

   assign nibble  = ~s2[W-1:1];
   assign stb_evt = ~s2[0] & s3;

endmodule

// File: rtl/inv_nibble_link_rx.sv
// rtl/inv_nibble_link_rx.sv - reassembles bytes from inverted nibbles and muxes byte/status onto io_out
module inv_nibble_link_rx
   import inv_nibble_link_rx_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic       clk;
   logic       rst;
   logic       view;
   logic [3:0] nibble;
   logic       stb_evt;

   state_t     state;
   logic [3:0] hi;
   logic [7:0] rx_byte;
   logic [3:0] byte_cnt;
   logic [7:0] tmo;
   logic       fresh;
   logic       to_err;
   logic       half;

   assign clk  = io_in[PIN_CLK];
   assign rst  = io_in[PIN_RST];
   assign view = io_in[PIN_VIEW];

   inv_link_sync #(.W(5)) u_sync (
      .clk     (clk),
      .rst     (rst),
      .raw     (io_in[PIN_DAT_LO+3:PIN_STB]),
      .nibble  (nibble),
      .stb_evt (stb_evt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         hi       <= 4'h0;
         rx_byte  <= 8'h00;
         byte_cnt <= 4'h0;
         tmo      <= 8'h00;
         fresh    <= 1'b0;
         to_err   <= 1'b0;
      end else begin
         // a completion later in this block overrides the view-0 clear
         if (!view) fresh <= 1'b0;
         case (state)
            IDLE: begin
               if (stb_evt) begin
                  hi    <= nibble;
                  tmo   <= 8'h00;
                  state <= HALF;
               end
            end
            HALF: begin
               if (stb_evt) begin
                  rx_byte  <= {hi, nibble};
                  byte_cnt <= byte_cnt + 4'd1;
                  fresh    <= 1'b1;
                  state    <= IDLE;
               end else if (tmo == TMO_LAST) begin
                  to_err <= 1'b1;
                  state  <= IDLE;
               end else begin
                  tmo <= tmo + 8'd1;
               end
            end
         endcase
      end
   end

   assign half = (state == HALF);

   always_comb begin
      io_out = rx_byte;
      if (view) io_out = {byte_cnt, half, fresh, to_err, STATUS_MARK};
   end

endmodule

// File: tb/tb_inv_nibble_link_rx.sv
// tb/tb_inv_nibble_link_rx.sv - scoreboard bench for the inverted nibble link receiver
module tb_inv_nibble_link_rx;

   localparam int TMO = 255;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       stb_n  = 1'b1;
   logic [3:0] dat_n  = 4'hF;
   logic       view   = 1'b0;
   logic [7:0] io_in;
   logic [7:0] io_out;

   int   cyc      = 0;
   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];

   logic [3:0] exp_cnt = 4'h0;
   logic       exp_err = 1'b0;

   assign io_in = {view, dat_n, stb_n, rst, clk};

   inv_nibble_link_rx #(.TIMEOUT_CYCLES(TMO)) dut (
      .io_in  (io_in),
      .io_out (io_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // pop and compare each byte on the cycle its second strobe should land
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         if (sb[0].due == cyc) begin
            check("byte", io_out, sb[0].data);
            void'(sb.pop_front());
         end else if (sb[0].due < cyc) begin
            check("byte_missed", 8'hFF, sb[0].data);
            void'(sb.pop_front());
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      stb_n = 1'b1;
      dat_n = 4'hF;
      view  = 1'b0;
      repeat (2) @(negedge clk);
      rst     = 1'b0;
      exp_cnt = 4'h0;
      exp_err = 1'b0;
   endtask

   // low sample lands on the next posedge; byte result visible two edges later
   task automatic send_nibble(input logic [3:0] n, input bit last, input logic [7:0] b);
      @(negedge clk);
      stb_n = 1'b1;
      dat_n = ~n;
      @(negedge clk);
      stb_n = 1'b0;
      if (last) begin
         sb.push_back('{data: b, due: cyc + 3});
         exp_cnt = exp_cnt + 4'd1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_nibble(b[7:4], 1'b0, 8'h00);
      send_nibble(b[3:0], 1'b1, b);
   endtask

   task automatic release_stb();
      @(negedge clk);
      stb_n = 1'b1;
   endtask

   task automatic idle_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 20) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (sb.size() > 0) begin
         check("drain_timeout", 8'h00, 8'hFF);
         sb.delete();
      end
   endtask

   task automatic check_status(input string tag, input logic half, input logic fresh);
      #1 view = 1'b1;
      #1 check(tag, io_out, {exp_cnt, half, fresh, exp_err, 1'b1});
      view = 1'b0;
   endtask

   initial begin
      int k1;

      do_reset();
      #1 check("reset_byte", io_out, 8'h00);
      check_status("reset_status", 1'b0, 1'b0);

      // single byte, a spare idle cycle between strobes
      send_nibble(4'hA, 1'b0, 8'h00);
      release_stb();
      send_nibble(4'h5, 1'b1, 8'hA5);
      release_stb();
      drain();
      check_status("single_fresh", 1'b0, 1'b1);
      @(negedge clk);
      check_status("single_after_view0", 1'b0, 1'b0);

      // 16 bytes back to back wraps the counter
      do_reset();
      for (int i = 0; i < 16; i++) send_byte(8'((i * 37 + 11) ^ 8'h5A));
      release_stb();
      drain();
      check_status("wrap_status", 1'b0, 1'b1);
      check("wrap_cnt_zero", {4'h0, exp_cnt}, 8'h00);

      // lone high nibble times out
      do_reset();
      send_nibble(4'h9, 1'b0, 8'h00);
      k1 = cyc + 1;
      release_stb();
      idle_until(k1 + TMO + 1);
      check_status("tmo_edge_minus1", 1'b1, 1'b0);
      idle_until(k1 + TMO + 2);
      exp_err = 1'b1;
      check_status("tmo_fired", 1'b0, 1'b0);
      #1 check("tmo_byte_kept", io_out, 8'h00);
      send_byte(8'h3C);
      release_stb();
      drain();
      check_status("tmo_then_byte", 1'b0, 1'b1);

      // second strobe lands on the cycle the timeout would fire
      do_reset();
      send_nibble(4'hC, 1'b0, 8'h00);
      k1 = cyc + 1;
      idle_until(k1 + TMO - 3);
      send_nibble(4'h3, 1'b1, 8'hC3);
      release_stb();
      drain();
      check_status("race_status", 1'b0, 1'b1);
      idle_until(cyc + TMO + 5);
      check_status("race_no_late_err", 1'b0, 1'b0);

      // reset while half a byte is pending
      do_reset();
      send_byte(8'h12);
      release_stb();
      drain();
      send_nibble(4'h4, 1'b0, 8'h00);
      release_stb();
      repeat (3) @(negedge clk);
      check_status("mid_half", 1'b1, 1'b0);
      do_reset();
      #1 check("mid_reset_byte", io_out, 8'h00);
      check_status("mid_reset_status", 1'b0, 1'b0);
      send_byte(8'h7E);
      release_stb();
      drain();
      check_status("mid_next_byte", 1'b0, 1'b1);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "bench time limit");
   end

endmodule
